// File: rtl/queen_pkg.sv
// Shared definitions for the N-queens placement checker: board defaults,
// FSM state encoding and the diagonal mask index helpers.
package queen_pkg;

    localparam int N_DEF  = 8;
    localparam int LN_DEF = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        REPORT = 2'd2
    } state_t;

    // Sum diagonal: constant k+j, range 0..2N-2.
    function automatic int sum_idx(input int k, input int j);
        return k + j;
    endfunction

    // Difference diagonal offset by N so the index stays non-negative (1..2N-1).
    function automatic int dif_idx(input int k, input int j, input int n = N_DEF);
        return n - k + j;
    endfunction

endpackage

// File: rtl/queen_checker_if.sv
// Column stream handshake between a placement source and the checker.
interface queen_checker_if #(
    parameter int LN = 5
);
    logic          col_valid;
    logic [LN-1:0] col;
    logic          col_ready;

    modport master (output col_valid, output col, input col_ready);
    modport slave  (input col_valid, input col, output col_ready);
endinterface

// File: rtl/queen_occupancy.sv
// Column, sum-diagonal and difference-diagonal occupancy masks with a
// combinational hit flag for the row/column currently presented.
module queen_occupancy
    import queen_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int LN = LN_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          set,
    input  logic [LN-1:0] row,
    input  logic [LN-1:0] col,
    output logic          hit
);

    localparam logic [LN-1:0] N_L = LN'(N);

    logic [N-1:0]   mh;
    logic [2*N-1:0] ms;
    logic [2*N-1:0] md;
    logic [N-1:0]   mh_sh;
    logic [2*N-1:0] ms_sh;
    logic [2*N-1:0] md_sh;
    logic [LN:0]    s_idx;
    logic [LN:0]    d_idx;
    logic           in_range;

    assign in_range = (col < N_L);
    assign s_idx    = (LN+1)'(sum_idx(int'(row), int'(col)));
    assign d_idx    = (LN+1)'(dif_idx(int'(row), int'(col), N));

    // Shifting instead of indexing keeps out-of-range columns harmless.
    assign mh_sh = mh >> col;
    assign ms_sh = ms >> s_idx;
    assign md_sh = md >> d_idx;

    assign hit = !in_range || mh_sh[0] || ms_sh[0] || md_sh[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mh <= '0;
            ms <= '0;
            md <= '0;
        end else if (clear) begin
            mh <= '0;
            ms <= '0;
            md <= '0;
        end else if (set && in_range) begin
            mh <= mh | (N'(1) << col);
            ms <= ms | ((2*N)'(1) << s_idx);
            md <= md | ((2*N)'(1) << d_idx);
        end
    end

endmodule

// File: rtl/queen_checker.sv
// Streams one column per row, flags the first illegal or attacked row,
// reports a one-cycle verdict and counts passing boards.
module queen_checker
    import queen_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int LN = LN_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    queen_checker_if.slave  cbus,
    input  logic            start,
    output logic            done,
    output logic            ok,
    output logic [LN-1:0]   conflict_row,
    output logic [31:0]     boards_ok
);

    localparam logic [LN-1:0] N_L    = LN'(N);
    localparam logic [LN-1:0] K_LAST = LN'(N - 1);

    state_t        state;
    state_t        state_nxt;
    logic [LN-1:0] k;
    logic          bad;
    logic          accept;
    logic          last_row;
    logic          hit;
    logic          report;

    // A beat coinciding with start belongs to no board and is dropped.
    assign accept   = cbus.col_valid && cbus.col_ready && !start;
    assign last_row = (k == K_LAST);

    queen_occupancy #(
        .N  (N),
        .LN (LN)
    ) u_occ (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (start),
        .set   (accept),
        .row   (k),
        .col   (cbus.col),
        .hit   (hit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (start) begin
            state_nxt = LOAD;
        end else begin
            case (state)
                IDLE:    state_nxt = IDLE;
                LOAD:    if (accept && last_row) state_nxt = REPORT;
                REPORT:  state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        cbus.col_ready = (state == LOAD);
        report         = (state == REPORT) && !start;
    end

    // The verdict registers update on the edge that leaves REPORT, so done
    // rises one edge after the last row is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k            <= '0;
            bad          <= 1'b0;
            done         <= 1'b0;
            ok           <= 1'b0;
            conflict_row <= '0;
            boards_ok    <= '0;
        end else if (start) begin
            k            <= '0;
            bad          <= 1'b0;
            done         <= 1'b0;
            ok           <= 1'b0;
            conflict_row <= N_L;
        end else begin
            done <= report;
            if (accept) begin
                if (!last_row) k <= k + 1'b1;
                if (hit && !bad) begin
                    bad          <= 1'b1;
                    conflict_row <= k;
                end
            end
            if (report) begin
                ok <= !bad;
                if (!bad) boards_ok <= boards_ok + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_queen_checker.sv
// Directed bench for queen_checker: table of 8-row boards with expected
// verdicts, plus restart-mid-board and reset-mid-board sequences.
module tb_queen_checker;
    import queen_pkg::*;

    localparam int N  = 8;
    localparam int LN = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          done;
    logic          ok;
    logic [LN-1:0] conflict_row;
    logic [31:0]   boards_ok;

    queen_checker_if #(.LN(LN)) cbus ();

    queen_checker #(.N(N), .LN(LN)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cbus         (cbus),
        .start        (start),
        .done         (done),
        .ok           (ok),
        .conflict_row (conflict_row),
        .boards_ok    (boards_ok)
    );

    always #5 clk = ~clk;

    int checks     = 0;
    int failures   = 0;
    int done_cnt   = 0;
    int exp_boards = 0;

    always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    typedef struct {
        logic [39:0] cols;
        bit          gaps;
        bit          exp_ok;
        int          exp_cr;
        string       name;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [39:0] pack8(input int a, input int b, input int c, input int d,
                                          input int e, input int f, input int g, input int h);
        return {5'(h), 5'(g), 5'(f), 5'(e), 5'(d), 5'(c), 5'(b), 5'(a)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input string name);
        start = 1'b1;
        step();
        start = 1'b0;
        chk({name, "_start_cr"}, 32'(conflict_row), N);
        chk({name, "_start_ok"}, 32'(ok), 0);
        chk({name, "_start_ready"}, 32'(cbus.col_ready), 1);
    endtask

    task automatic send_row(input int j, input bit gaps, input string name);
        int t;
        if (gaps) repeat ($urandom_range(0, 2)) step();
        cbus.col_valid = 1'b1;
        cbus.col       = 5'(j);
        t = 0;
        while (cbus.col_ready !== 1'b1 && t < 20) begin
            step();
            t++;
        end
        if (t == 20) begin
            failures++;
            $display("FAIL %s_ready_timeout actual=0 expected=1", name);
        end
        step();
        cbus.col_valid = 1'b0;
    endtask

    task automatic send_board(input logic [39:0] cols, input bit gaps, input string name);
        for (int r = 0; r < N; r++) send_row(int'(cols[r*5 +: 5]), gaps, name);
    endtask

    task automatic finish_board(input bit exp_ok, input int exp_cr, input int d0, input string name);
        chk({name, "_done_early"}, 32'(done), 0);
        step();
        chk({name, "_done"}, 32'(done), 1);
        chk({name, "_ok"}, 32'(ok), 32'(exp_ok));
        chk({name, "_cr"}, 32'(conflict_row), exp_cr);
        if (exp_ok) exp_boards++;
        chk({name, "_boards"}, boards_ok, exp_boards);
        step();
        chk({name, "_done_fall"}, 32'(done), 0);
        chk({name, "_done_count"}, done_cnt - d0, 1);
        chk({name, "_hold_ok"}, 32'(ok), 32'(exp_ok));
        chk({name, "_idle_ready"}, 32'(cbus.col_ready), 0);
    endtask

    task automatic run_board(input vec_t v);
        int d0;
        d0 = done_cnt;
        do_start(v.name);
        send_board(v.cols, v.gaps, v.name);
        finish_board(v.exp_ok, v.exp_cr, d0, v.name);
    endtask

    initial begin
        int d0;
        vecs[0] = '{pack8(0, 4, 7, 5, 2, 6, 1, 3), 1'b0, 1'b1, 8, "legal_a"};
        vecs[1] = '{pack8(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0, 1, "col_clash"};
        vecs[2] = '{pack8(0, 1, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0, 1, "dif_diag"};
        vecs[3] = '{pack8(1, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0, 1, "sum_diag"};
        vecs[4] = '{pack8(0, 4, 7, 8, 1, 0, 0, 0), 1'b0, 1'b0, 3, "range_row3"};
        vecs[5] = '{pack8(0, 5, 7, 2, 6, 3, 1, 4), 1'b0, 1'b1, 8, "legal_b"};
        vecs[6] = '{pack8(0, 4, 7, 5, 2, 6, 1, 1), 1'b0, 1'b0, 7, "last_row"};
        vecs[7] = '{pack8(15, 4, 7, 5, 2, 6, 1, 3), 1'b1, 1'b0, 0, "range_row0_gaps"};

        rst_n          = 1'b0;
        start          = 1'b0;
        cbus.col_valid = 1'b0;
        cbus.col       = '0;
        #2;
        chk("rst_ready", 32'(cbus.col_ready), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_ok", 32'(ok), 0);
        chk("rst_cr", 32'(conflict_row), 0);
        chk("rst_boards", boards_ok, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("idle_ready", 32'(cbus.col_ready), 0);

        for (int i = 0; i < 8; i++) run_board(vecs[i]);

        // Restart mid-board: partial board, start with a coincident beat, fresh board.
        d0 = done_cnt;
        do_start("restart_a");
        for (int r = 0; r < 4; r++) send_row(int'(vecs[0].cols[r*5 +: 5]), 1'b1, "restart_a");
        start          = 1'b1;
        cbus.col_valid = 1'b1;
        cbus.col       = 5'd3;
        step();
        start          = 1'b0;
        cbus.col_valid = 1'b0;
        chk("restart_cr", 32'(conflict_row), N);
        chk("restart_no_done", done_cnt - d0, 0);
        send_board(vecs[0].cols, 1'b1, "restart_b");
        finish_board(1'b1, N, d0, "restart_b");

        // Reset mid-board returns everything at once and never yields done.
        d0 = done_cnt;
        do_start("rstmid");
        for (int r = 0; r < 5; r++) send_row(int'(vecs[5].cols[r*5 +: 5]), 1'b0, "rstmid");
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_ready", 32'(cbus.col_ready), 0);
        chk("rstmid_done", 32'(done), 0);
        chk("rstmid_ok", 32'(ok), 0);
        chk("rstmid_cr", 32'(conflict_row), 0);
        chk("rstmid_boards", boards_ok, 0);
        exp_boards = 0;
        step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("rstmid_no_done", done_cnt - d0, 0);
        run_board('{vecs[0].cols, 1'b0, 1'b1, 8, "after_rst"});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
